split_tree_n: RTL and testbench

SPLIT_TREE_N -- requirements
Module: split_tree_n

---
 rtl/split_tree_n.sv | 102 ++++++++++
 tb/tb_split_tree_n.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/split_tree_n.sv
// Toggle-encoded pulse fan-out: each accepted input pulse is delayed by the depth of a binary
// split tree and then toggles every channel that was enabled when the pulse was accepted.
module split_tree_n #(
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned STAGE_LAT = 1,
  parameter int unsigned CT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic [N_OUT-1:0] en_mask,
  input  logic             viol_clr,
  output logic [N_OUT-1:0] q,
  output logic             viol,
  output logic [15:0]      pulse_cnt
);

  localparam int unsigned DEPTH     = $clog2(N_OUT);
  localparam int unsigned LAT       = DEPTH * STAGE_LAT;
  localparam logic [3:0]  HOLD_LOAD = 4'(CT_CYCLES - 1);

  logic             a_d_q;
  logic [3:0]       hold_q, hold_d;
  logic             viol_q, viol_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [N_OUT-1:0] q_q, q_d;
  logic [LAT-1:0]   vld_q, vld_d;
  logic [N_OUT-1:0] mask_q [LAT];
  logic [N_OUT-1:0] mask_d [LAT];

  logic pulse, accept, drop;

  assign pulse  = (a != a_d_q);
  assign accept = pulse && (hold_q == 4'd0);
  assign drop   = pulse && (hold_q != 4'd0);

  always_comb begin
    hold_d = hold_q;
    if (accept) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != 4'd0) begin
      hold_d = hold_q - 4'd1;
    end
  end

  // A fresh violation outranks a simultaneous clear.
  assign viol_d = drop | (viol_q & ~viol_clr);

  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    vld_d     = '0;
    mask_d[0] = accept ? en_mask : '0;
    vld_d[0]  = accept;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      mask_d[i] = mask_q[i-1];
    end
  end

  always_comb begin
    q_d = q_q;
    if (vld_q[LAT-1]) begin
      q_d = q_q ^ mask_q[LAT-1];
    end
  end

  // a_d follows a during reset so that release never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_d_q  <= a;
      hold_q <= 4'd0;
      viol_q <= 1'b0;
      cnt_q  <= 16'd0;
      q_q    <= '0;
      vld_q  <= '0;
      for (int i = 0; i < LAT; i++) begin
        mask_q[i] <= '0;
      end
    end else begin
      a_d_q  <= a;
      hold_q <= hold_d;
      viol_q <= viol_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      vld_q  <= vld_d;
      for (int i = 0; i < LAT; i++) begin
        mask_q[i] <= mask_d[i];
      end
    end
  end

  assign q         = q_q;
  assign viol      = viol_q;
  assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_split_tree_n.sv
// Scoreboard bench for split_tree_n: three configurations, expected toggles queued by the driver
// and matched (value and edge number) by a monitor whenever an output changes.
module tb_split_tree_n;

  typedef struct packed {
    int         cyc;
    logic [3:0] v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  exp_t exp0[$];
  exp_t exp1[$];
  exp_t exp2[$];

  // dut0: N_OUT=4 STAGE_LAT=1 CT_CYCLES=2 (LAT=2)
  logic       rst0, a0, clr0, viol0;
  logic [3:0] en0, q0;
  logic [15:0] cnt0;
  // dut1: N_OUT=3 STAGE_LAT=2 CT_CYCLES=2 (LAT=4)
  logic       rst1, a1, clr1, viol1;
  logic [2:0] en1, q1;
  logic [15:0] cnt1;
  // dut2: N_OUT=4 STAGE_LAT=1 CT_CYCLES=1 (LAT=2)
  logic       rst2, a2, clr2, viol2;
  logic [3:0] en2, q2;
  logic [15:0] cnt2;

  split_tree_n #(.N_OUT(4), .STAGE_LAT(1), .CT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst0), .a(a0), .en_mask(en0), .viol_clr(clr0),
    .q(q0), .viol(viol0), .pulse_cnt(cnt0)
  );
  split_tree_n #(.N_OUT(3), .STAGE_LAT(2), .CT_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst1), .a(a1), .en_mask(en1), .viol_clr(clr1),
    .q(q1), .viol(viol1), .pulse_cnt(cnt1)
  );
  split_tree_n #(.N_OUT(4), .STAGE_LAT(1), .CT_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst2), .a(a2), .en_mask(en2), .viol_clr(clr2),
    .q(q2), .viol(viol2), .pulse_cnt(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (edge %0d)", name, got, want, cyc);
    end
  endtask

  task automatic extra(input string name, input logic [3:0] got);
    checks++;
    failures++;
    $display("FAIL %s: unexpected toggle to %0h at edge %0d", name, got, cyc);
  endtask

  // Monitor: any change on q must match the oldest queued expectation.
  logic [3:0] p0 = '0, p1 = '0, p2 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (q0 !== p0) begin
        if (exp0.size() == 0) extra("dut0_q", q0);
        else begin
          e = exp0.pop_front();
          chk("dut0_q_val", q0, e.v);
          chk("dut0_q_edge", cyc, e.cyc);
        end
      end
      if ({1'b0, q1} !== p1) begin
        if (exp1.size() == 0) extra("dut1_q", {1'b0, q1});
        else begin
          e = exp1.pop_front();
          chk("dut1_q_val", {1'b0, q1}, e.v);
          chk("dut1_q_edge", cyc, e.cyc);
        end
      end
      if (q2 !== p2) begin
        if (exp2.size() == 0) extra("dut2_q", q2);
        else begin
          e = exp2.pop_front();
          chk("dut2_q_val", q2, e.v);
          chk("dut2_q_edge", cyc, e.cyc);
        end
      end
    end
    p0 <= q0;
    p1 <= {1'b0, q1};
    p2 <= q2;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drivers are called on a negedge; the pulse is detected at edge cyc+1.
  task automatic pulse0(input logic [3:0] m, input bit expect_it, input logic [3:0] v);
    en0 = m;
    a0  = ~a0;
    if (expect_it) exp0.push_back('{cyc: cyc + 1 + 2, v: v});
  endtask
  task automatic pulse1(input logic [2:0] m, input logic [3:0] v);
    en1 = m;
    a1  = ~a1;
    exp1.push_back('{cyc: cyc + 1 + 4, v: v});
  endtask
  task automatic pulse2(input logic [3:0] m, input bit expect_it, input logic [3:0] v);
    en2 = m;
    a2  = ~a2;
    if (expect_it) exp2.push_back('{cyc: cyc + 1 + 2, v: v});
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    a0 = 1'b0; a1 = 1'b0; a2 = 1'b0;
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    en0 = 4'hF; en1 = 3'b111; en2 = 4'hF;
    tick(3);
    chk("rst_q0", q0, 0);
    chk("rst_viol0", viol0, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_q1", {1'b0, q1}, 0);
    chk("rst_q2", q2, 0);
    chk("rst_cnt2", cnt2, 0);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // Single pulse, full mask.
    pulse0(4'hF, 1, 4'hF); tick(4);
    chk("single_cnt", cnt0, 1);
    chk("single_viol", viol0, 0);

    // Second pulse inside holdoff is dropped and flags a violation.
    pulse0(4'hF, 1, 4'h0); tick(1);
    pulse0(4'hF, 0, 4'h0); tick(1);
    chk("drop_viol", viol0, 1);
    tick(4);
    chk("drop_cnt", cnt0, 2);
    chk("drop_viol_sticky", viol0, 1);
    clr0 = 1'b1; tick(1); clr0 = 1'b0;
    chk("viol_clr", viol0, 0);

    // Violation and clear on the same edge: set wins.
    pulse0(4'hF, 1, 4'hF); tick(1);
    pulse0(4'hF, 0, 4'h0); clr0 = 1'b1; tick(1); clr0 = 1'b0;
    chk("set_wins", viol0, 1);
    tick(4);
    chk("set_wins_cnt", cnt0, 3);
    clr0 = 1'b1; tick(1); clr0 = 1'b0;

    // All-zero mask still counts and still arms holdoff.
    pulse0(4'h0, 0, 4'h0); tick(1);
    pulse0(4'h0, 0, 4'h0); tick(1);
    chk("mask0_holdoff_viol", viol0, 1);
    tick(3);
    chk("mask0_cnt", cnt0, 4);
    clr0 = 1'b1; tick(1); clr0 = 1'b0;

    // Partial masks: F ^ 5 = A, A ^ A = 0.
    pulse0(4'h5, 1, 4'hA); tick(2);
    pulse0(4'hA, 1, 4'h0); tick(4);
    chk("partial_cnt", cnt0, 6);

    // Reset one edge after acceptance kills the in-flight pulse; a toggle during reset is lost.
    pulse0(4'hF, 0, 4'h0); tick(1);
    rst0 = 1'b1; a0 = ~a0; tick(1);
    rst0 = 1'b0; tick(10);
    chk("rst_mid_q", q0, 0);
    chk("rst_mid_cnt", cnt0, 0);
    chk("rst_mid_viol", viol0, 0);
    pulse0(4'hF, 1, 4'hF); tick(4);
    chk("post_rst_cnt", cnt0, 1);

    // LAT=4 with non-power-of-2 width; mask change after acceptance has no effect.
    pulse1(3'b101, 4'h5); tick(1);
    en1 = 3'b010; tick(5);
    pulse1(3'b010, 4'h7); tick(6);
    chk("dut1_cnt", cnt1, 2);
    chk("dut1_viol", viol1, 0);

    // CT_CYCLES=1: consecutive pulses toggle on consecutive edges.
    pulse2(4'hF, 1, 4'hF); tick(1);
    pulse2(4'hF, 1, 4'h0); tick(1);
    pulse2(4'hF, 1, 4'hF); tick(4);
    chk("b2b_cnt", cnt2, 3);
    chk("b2b_viol", viol2, 0);

    // Drive the counter to saturation, then check it sticks while outputs keep toggling.
    for (int i = 0; i < 65532; i++) begin
      pulse2(4'h0, 0, 4'h0); tick(1);
    end
    tick(3);
    chk("sat_reach", cnt2, 16'hFFFF);
    pulse2(4'hF, 1, 4'h0); tick(1);
    pulse2(4'hF, 1, 4'hF); tick(4);
    chk("sat_hold", cnt2, 16'hFFFF);
    chk("sat_viol", viol2, 0);

    tick(6);
    chk("dut0_pending", exp0.size(), 0);
    chk("dut1_pending", exp1.size(), 0);
    chk("dut2_pending", exp2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
